// File: rtl/axi_sram_slave.sv
// AXI4 burst slave in front of a 2^MEM_AW x 32-bit SRAM.
// Independent read and write channel FSMs, one outstanding burst each.
module axi_sram_slave #(
  parameter int MEM_AW = 12
) (
  input  logic        clk,
  input  logic        reset,
  // read address / data
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address / data / response
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW    = MEM_AW + 2;
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  logic [31:0] mem [DEPTH];

  // Only the byte address bits that reach the word index are kept; the rest alias.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [2:0]    size,
                                              input logic [1:0]    burst);
    if (burst == 2'b00) return a;
    return a + (AW'(1) << size);
  endfunction

  // ------------------------------------------------------------------
  // Read channel
  // ------------------------------------------------------------------
  r_state_t        r_state, r_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [3:0]      r_len;
  logic [3:0]      r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            ar_hs;
  logic            r_hs;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rlast       = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == r_len);
        if (rready && (r_cnt == r_len)) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                r_cnt <= '0;
    else if (ar_hs)           r_cnt <= '0;
    else if (r_hs && !rlast)  r_cnt <= r_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      r_addr  <= araddr[AW-1:0];
      r_len   <= arlen[3:0];
      r_size  <= arsize;
      r_burst <= arburst;
    end else if (r_hs && !rlast) begin
      r_addr  <= next_addr(r_addr, r_size, r_burst);
    end
  end

  // Combinational read: a write landing this edge is visible only from the next cycle.
  assign rdata = mem[r_addr[AW-1:2]];
  assign rresp = 2'b00;

  // ------------------------------------------------------------------
  // Write channel
  // ------------------------------------------------------------------
  w_state_t        w_state, w_state_nxt;
  logic [AW-1:0]   w_addr;
  logic [3:0]      w_len;
  logic [3:0]      w_cnt;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic            w_err;
  logic            w_end;
  logic            aw_hs;
  logic            w_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign w_end = (w_cnt == w_len);

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    bresp       = 2'b00;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_end) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err ? 2'b10 : 2'b00;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)               w_cnt <= '0;
    else if (aw_hs)          w_cnt <= '0;
    else if (w_hs && !w_end) w_cnt <= w_cnt + 4'd1;
  end

  // A wlast that disagrees with the beat count flags the burst but never blocks the data.
  always_ff @(posedge clk) begin
    if (reset)                        w_err <= 1'b0;
    else if (aw_hs)                   w_err <= 1'b0;
    else if (w_hs && (wlast != w_end)) w_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      w_addr  <= awaddr[AW-1:0];
      w_len   <= awlen[3:0];
      w_size  <= awsize;
      w_burst <= awburst;
    end else if (w_hs && !w_end) begin
      w_addr  <= next_addr(w_addr, w_size, w_burst);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_addr[AW-1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{araddr[31:AW], awaddr[31:AW], arlen[7:4], awlen[7:4]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus randomized
// bursts compared against a word-array model of the memory.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_sram_slave #(.MEM_AW(12)) dut (
    .clk(clk), .reset(reset),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tmo = 0;

  // memory model: one 32-bit word per index, byte lanes written by strobe
  logic [31:0] ref_mem [4096];

  logic [31:0] wb_data [16];
  logic [3:0]  wb_strb [16];
  logic        wb_last [16];
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  int          rd_stall_err;
  int          rd_resp_bad;
  bit          rd_lat_ok;
  bit          rd_post_idle;
  logic [1:0]  wr_bresp;
  int          wr_hold_err;

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return start;
    return start + 32'(i) * (32'd1 << size);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] start, input int i,
                                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    a = beat_addr(start, i, size, burst);
    return ref_mem[a[13:2]];
  endfunction

  task automatic model_apply_write(input logic [31:0] start, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(start, i, size, burst);
      for (int b = 0; b < 4; b++)
        if (wb_strb[i][b]) ref_mem[a[13:2]][8*b +: 8] = wb_data[i][8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int hold_b, input bit gaps);
    int guard;
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) tmo++;
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin wvalid = 1'b0; @(posedge clk); #1; end
      wvalid = 1'b1; wdata = wb_data[i]; wstrb = wb_strb[i]; wlast = wb_last[i];
      guard = 0;
      while (!wready && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) tmo++;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    guard = 0;
    while (!bvalid && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) tmo++;
    wr_bresp = bresp;
    wr_hold_err = 0;
    for (int k = 0; k < hold_b; k++) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1 || bresp !== wr_bresp) wr_hold_err++;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // mode 0: rready always 1; 1: toggles 1/0; 2: random. Stops early after abort_after beats.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode, input int abort_after);
    int guard;
    int beats;
    bit held;
    bit tog;
    logic [31:0] held_data;
    araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) tmo++;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rd_lat_ok = (rvalid === 1'b1);
    beats = 0; held = 0; tog = 1; held_data = '0;
    rd_stall_err = 0; rd_resp_bad = 0; guard = 0;
    while (beats <= len && beats != abort_after && guard < 400) begin
      case (mode)
        0:       rready = 1'b1;
        1:       begin rready = tog; tog = !tog; end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rvalid) begin
        if (held && rdata !== held_data) rd_stall_err++;
        if (rresp !== 2'b00) rd_resp_bad++;
        if (rready) begin
          rd_data[beats] = rdata; rd_last[beats] = rlast; beats++; held = 0;
        end else begin
          held = 1; held_data = rdata;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 400) tmo++;
    if (abort_after < 0) rready = 1'b0;
    rd_post_idle = (rvalid === 1'b0 && arready === 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL reset_arready got=%b exp=1", arready); end
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL reset_awready got=%b exp=1", awready); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    total++; if (rlast !== 1'b0) begin bad++; $display("FAIL reset_rlast got=%b exp=0", rlast); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%b exp=0", wready); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%b exp=0", bvalid); end
    total++; if (rresp !== 2'b00) begin bad++; $display("FAIL reset_rresp got=%b exp=00", rresp); end
    total++; if (bresp !== 2'b00) begin bad++; $display("FAIL reset_bresp got=%b exp=00", bresp); end
  endtask

  task automatic test_single;
    wb_data[0] = 32'hDEADBEEF; wb_strb[0] = 4'hF; wb_last[0] = 1'b1;
    do_write(32'h10, 0, 3'd2, 2'b01, 0, 0);
    model_apply_write(32'h10, 0, 3'd2, 2'b01);
    total++; if (wr_bresp !== 2'b00) begin bad++; $display("FAIL single_bresp got=%b exp=00", wr_bresp); end
    do_read(32'h10, 0, 3'd2, 2'b01, 0, -1);
    total++; if (rd_lat_ok !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", rd_lat_ok); end
    total++; if (rd_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rd_data[0]); end
    total++; if (rd_last[0] !== 1'b1) begin bad++; $display("FAIL single_rlast got=%b exp=1", rd_last[0]); end
    total++; if (rd_post_idle !== 1'b1) begin bad++; $display("FAIL single_post_idle got=%b exp=1", rd_post_idle); end
  endtask

  task automatic test_incr16;
    for (int i = 0; i < 16; i++) begin
      wb_data[i] = 32'(i); wb_strb[i] = 4'hF; wb_last[i] = (i == 15);
    end
    do_write(32'h100, 15, 3'd2, 2'b01, 0, 1);
    model_apply_write(32'h100, 15, 3'd2, 2'b01);
    total++; if (wr_bresp !== 2'b00) begin bad++; $display("FAIL incr16_bresp got=%b exp=00", wr_bresp); end
    do_read(32'h100, 15, 3'd2, 2'b01, 1, -1);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rd_data[i] !== 32'(i)) begin bad++; $display("FAIL incr16_rdata beat=%0d got=%h exp=%h", i, rd_data[i], 32'(i)); end
      total++;
      if (rd_last[i] !== (i == 15)) begin bad++; $display("FAIL incr16_rlast beat=%0d got=%b", i, rd_last[i]); end
    end
    total++; if (rd_stall_err !== 0) begin bad++; $display("FAIL incr16_stall_hold got=%0d exp=0", rd_stall_err); end
    total++; if (rd_resp_bad !== 0) begin bad++; $display("FAIL incr16_rresp got=%0d exp=0", rd_resp_bad); end
  endtask

  task automatic test_strobe;
    wb_data[0] = 32'h11223344; wb_strb[0] = 4'hF; wb_last[0] = 1'b1;
    do_write(32'h20, 0, 3'd2, 2'b01, 0, 0);
    model_apply_write(32'h20, 0, 3'd2, 2'b01);
    wb_data[0] = 32'h00AA0000; wb_strb[0] = 4'b0100; wb_last[0] = 1'b1;
    do_write(32'h20, 0, 3'd2, 2'b01, 0, 0);
    model_apply_write(32'h20, 0, 3'd2, 2'b01);
    do_read(32'h20, 0, 3'd2, 2'b01, 0, -1);
    total++; if (rd_data[0] !== 32'h11AA3344) begin bad++; $display("FAIL strobe_rdata got=%h exp=11aa3344", rd_data[0]); end
  endtask

  task automatic test_wlast_err;
    for (int i = 0; i < 4; i++) begin
      wb_data[i] = $urandom; wb_strb[i] = 4'hF; wb_last[i] = (i == 1);
    end
    do_write(32'h300, 3, 3'd2, 2'b01, 5, 0);
    model_apply_write(32'h300, 3, 3'd2, 2'b01);
    total++; if (wr_bresp !== 2'b10) begin bad++; $display("FAIL wlast_bresp got=%b exp=10", wr_bresp); end
    total++; if (wr_hold_err !== 0) begin bad++; $display("FAIL wlast_bvalid_hold got=%0d exp=0", wr_hold_err); end
    do_read(32'h300, 3, 3'd2, 2'b01, 0, -1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== model_read(32'h300, i, 3'd2, 2'b01)) begin
        bad++; $display("FAIL wlast_rdata beat=%0d got=%h exp=%h", i, rd_data[i], model_read(32'h300, i, 3'd2, 2'b01));
      end
    end
  endtask

  task automatic test_wready_gate;
    wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (wready !== 1'b0) begin bad++; $display("FAIL wready_gate cycle=%0d got=%b exp=0", k, wready); end
    end
    wvalid = 1'b0; wlast = 1'b0;
    do_read(32'h10, 0, 3'd2, 2'b01, 0, -1);
    total++; if (rd_data[0] !== ref_mem[4]) begin bad++; $display("FAIL wready_gate_mem got=%h exp=%h", rd_data[0], ref_mem[4]); end
  endtask

  task automatic test_same_word;
    logic [31:0] old_v;
    logic [31:0] new_v;
    old_v = $urandom; new_v = ~old_v;
    wb_data[0] = old_v; wb_strb[0] = 4'hF; wb_last[0] = 1'b1;
    do_write(32'h40, 0, 3'd2, 2'b01, 0, 0);
    model_apply_write(32'h40, 0, 3'd2, 2'b01);
    araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = new_v; wstrb = 4'hF; wlast = 1'b1;
    total++; if (rdata !== old_v) begin bad++; $display("FAIL same_word_before got=%h exp=%h", rdata, old_v); end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    wb_data[0] = new_v;
    model_apply_write(32'h40, 0, 3'd2, 2'b01);
    total++; if (rdata !== new_v) begin bad++; $display("FAIL same_word_after got=%h exp=%h", rdata, new_v); end
    total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("FAIL same_word_b got=%b/%b exp=1/00", bvalid, bresp); end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    total++; if (rvalid !== 1'b0 || awready !== 1'b1) begin bad++; $display("FAIL same_word_idle got=%b/%b exp=0/1", rvalid, awready); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      wb_data[i] = $urandom; wb_strb[i] = 4'hF; wb_last[i] = (i == 7);
    end
    do_write(32'h400, 7, 3'd2, 2'b01, 0, 0);
    model_apply_write(32'h400, 7, 3'd2, 2'b01);
    do_read(32'h400, 7, 3'd2, 2'b01, 0, 3);
    rready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL midreset_rvalid got=%b exp=0", rvalid); end
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL midreset_arready got=%b exp=1", arready); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_data[i] !== model_read(32'h400, i, 3'd2, 2'b01)) begin
        bad++; $display("FAIL midreset_partial beat=%0d got=%h", i, rd_data[i]);
      end
    end
    do_read(32'h400, 7, 3'd2, 2'b01, 2, -1);
    for (int i = 0; i < 8; i++) begin
      exp_v = model_read(32'h400, i, 3'd2, 2'b01);
      total++;
      if (rd_data[i] !== exp_v) begin bad++; $display("FAIL midreset_reread beat=%0d got=%h exp=%h", i, rd_data[i], exp_v); end
    end
  endtask

  task automatic test_random;
    logic [31:0] start;
    logic [31:0] exp_v;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  exp_b;
    int          len;
    // known contents for words 0x200..0x27f
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 16; i++) begin
        wb_data[i] = $urandom; wb_strb[i] = 4'hF; wb_last[i] = (i == 15);
      end
      do_write(32'h800 + 32'(blk * 64), 15, 3'd2, 2'b01, 0, 0);
      model_apply_write(32'h800 + 32'(blk * 64), 15, 3'd2, 2'b01);
    end
    for (int it = 0; it < 40; it++) begin
      start = (32'h200 + 32'($urandom_range(0, 32'h5F))) * 4 + 32'($urandom_range(0, 3));
      start[31:14] = 18'($urandom);
      len   = $urandom_range(0, 15);
      size  = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        exp_b = 2'b00;
        for (int i = 0; i <= len; i++) begin
          wb_data[i] = $urandom; wb_strb[i] = 4'($urandom); wb_last[i] = (i == len);
        end
        if ($urandom_range(0, 4) == 0) begin
          int k;
          k = $urandom_range(0, len);
          wb_last[k] = !wb_last[k];
          exp_b = 2'b10;
        end
        do_write(start, len, size, burst, $urandom_range(0, 2), 1);
        model_apply_write(start, len, size, burst);
        total++;
        if (wr_bresp !== exp_b) begin bad++; $display("FAIL rand_bresp it=%0d got=%b exp=%b", it, wr_bresp, exp_b); end
      end else begin
        do_read(start, len, size, burst, 2, -1);
        for (int i = 0; i <= len; i++) begin
          exp_v = model_read(start, i, size, burst);
          total++;
          if (rd_data[i] !== exp_v) begin bad++; $display("FAIL rand_rdata it=%0d beat=%0d got=%h exp=%h", it, i, rd_data[i], exp_v); end
          total++;
          if (rd_last[i] !== (i == len)) begin bad++; $display("FAIL rand_rlast it=%0d beat=%0d got=%b", it, i, rd_last[i]); end
        end
        total++;
        if (rd_stall_err !== 0 || rd_lat_ok !== 1'b1 || rd_post_idle !== 1'b1) begin
          bad++; $display("FAIL rand_timing it=%0d stall=%0d lat=%b idle=%b", it, rd_stall_err, rd_lat_ok, rd_post_idle);
        end
      end
    end
  endtask

  task automatic test_timeouts;
    total++; if (tmo !== 0) begin bad++; $display("FAIL handshake_timeouts got=%0d exp=0", tmo); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_incr16();
    test_strobe();
    test_wlast_err();
    test_wready_gate();
    test_same_word();
    test_mid_reset();
    test_random();
    test_timeouts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter MEM_AW, default 12, log2 of the memory depth in 32-bit words (2^MEM_AW words).
REQ-002 clk  input  1  sole clock; all logic samples on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 araddr  input  32  read burst start byte address.
REQ-005 arlen  input  8  read beats minus 1; only arlen[3:0] used (1..16 beats).
REQ-006 arsize  input  3  bytes per beat = 1<<arsize; legal values 0..2.
REQ-007 arburst  input  2  00 FIXED, 01 INCR; any other value is treated as INCR.
REQ-008 arvalid  input  1  read address valid.
REQ-009 arready  output  1  read address accepted.
REQ-010 rdata  output  32  read beat data (full word).
REQ-011 rresp  output  2  read response; always 00 (OKAY).
REQ-012 rlast  output  1  final read beat.
REQ-013 rvalid  output  1  read beat valid.
REQ-014 rready  input  1  master accepts read beat.
REQ-015 awaddr  input  32  write burst start byte address.
REQ-016 awlen  input  8  write beats minus 1; only awlen[3:0] used.
REQ-017 awsize  input  3  bytes per beat, same encoding as arsize.
REQ-018 awburst  input  2  same encoding as arburst.
REQ-019 awvalid  input  1  write address valid.
REQ-020 awready  output  1  write address accepted.
REQ-021 wdata  input  32  write beat data.
REQ-022 wstrb  input  4  byte enables; wstrb[i] enables wdata[8i+7:8i].
REQ-023 wlast  input  1  master's final-beat marker.
REQ-024 wvalid  input  1  write beat valid.
REQ-025 wready  output  1  write beat accepted.
REQ-026 bresp  output  2  write response: 00 OKAY, 10 SLVERR.
REQ-027 bvalid  output  1  write response valid.
REQ-028 bready  input  1  master accepts write response.

Function
REQ-029 Memory is 2^MEM_AW x 32 bits; word index = addr[MEM_AW+1:2]; upper address bits ignored (aliasing, no error).
REQ-030 Read and write FSMs are independent and run concurrently; each holds at most one outstanding burst.
REQ-031 Read FSM states: R_IDLE (arready=1), R_DATA (rvalid=1); arvalid&&arready latches addr/len/size/burst, zeroes beat counter, goes R_DATA next cycle.
REQ-032 In R_DATA, rdata = mem[current word index], held stable while rvalid&&!rready; rlast=1 iff beat counter == latched len[3:0].
REQ-033 On rvalid&&rready: non-last beat increments counter and advances address (INCR: +1<<size; FIXED: unchanged); last beat returns to R_IDLE, rvalid=0 next cycle.
REQ-034 First rvalid occurs exactly 1 cycle after the AR handshake; back-to-back beats at 1 per cycle while rready=1; next arready 1 cycle after the last beat handshake.
REQ-035 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); AW handshake latches addr/len/size/burst, clears counter and error flag.
REQ-036 In W_DATA on wvalid&&wready: bytes with wstrb set are written to the current word at that edge; address advances as in REQ-033.
REQ-037 Burst ends on the handshake where counter == len[3:0] -> W_RESP; wlast mismatch on any beat (1 early or 0 at end) sets error flag, bresp=10, data still written.
REQ-038 W_RESP holds bvalid and bresp until bready; bvalid&&bready -> W_IDLE, awready=1 next cycle.
REQ-039 wvalid before the AW handshake is not accepted (wready=0 outside W_DATA).
REQ-040 Same-cycle read and write to the same word: rdata shows pre-write contents that cycle, new contents from the next cycle.
REQ-041 Narrow transfers: address increments by 1<<size; word index crosses only at word boundaries; rdata always returns the full word.

Reset
REQ-042 reset=1 at a clock edge forces both FSMs idle: arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rresp=00, bresp=00, counters 0; any burst in progress is abandoned.
REQ-043 Memory contents are not cleared by reset and persist across a mid-burst reset.

Verification
REQ-044 Single write addr 0x10, awlen 0, wdata 0xDEADBEEF, wstrb F, wlast 1 -> bresp 00; then read 0x10 arlen 0 -> rdata 0xDEADBEEF, rlast 1, rvalid 1 cycle after AR.
REQ-045 INCR 16-beat write at 0x100 with data 0..15, then 16-beat read with rready toggling 1/0 -> rdata 0..15 in order, each held while stalled, rlast on beat 16 only.
REQ-046 Write 0x11223344 to 0x20, then wstrb 0100 wdata 0x00AA0000 -> read gives 0x11AA3344.
REQ-047 4-beat write (awlen 3) with wlast on beat 2 -> bresp 10, all 4 words written; bready held 0 for 5 cycles -> bvalid held 1 with bresp 10.
REQ-048 Reset asserted mid 8-beat read after beat 3 -> next cycle rvalid 0, arready 1; new read returns correct, unchanged memory contents.
